// File: rtl/muldiv_ctrl_if.sv
//------------------------------------------------------------------------------
// muldiv_ctrl_if
//   EXE-side issue/result handshake bundle for the multiply/divide sequencer.
//
//   Issue channel  : req_valid, req_ready, req_div, req_unsigned,
//                    req_src1, req_src2
//   Control        : flush (cancel in-flight op), busy (EXE stall)
//   Result channel : res_valid, res_ack, res_hi, res_lo
//
//   modport master : EXE pipeline stage (issues ops, consumes results)
//   modport slave  : muldiv_ctrl
//------------------------------------------------------------------------------
interface muldiv_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_div;
   logic        req_unsigned;
   logic [31:0] req_src1;
   logic [31:0] req_src2;
   logic        flush;
   logic        busy;
   logic        res_valid;
   logic        res_ack;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   modport master (
      output req_valid, req_div, req_unsigned, req_src1, req_src2,
      output flush, res_ack,
      input  req_ready, busy, res_valid, res_hi, res_lo
   );

   modport slave (
      input  req_valid, req_div, req_unsigned, req_src1, req_src2,
      input  flush, res_ack,
      output req_ready, busy, res_valid, res_hi, res_lo
   );
endinterface

// File: rtl/muldiv_ctrl.sv
//------------------------------------------------------------------------------
// muldiv_ctrl
//   Sequencer for the EXE-stage multiply/divide datapath. Accepts one
//   MULT/MULTU/DIV/DIVU issue, latches sign/zero-extended 33-bit operands,
//   drives a fixed-latency pipelined multiplier or a valid-handshake divider,
//   captures HI/LO and holds them until EXE acknowledges. Because the divider
//   cannot be cancelled, a flushed divide drains its pending output first.
//
// Parameters
//   MUL_LAT          clock edges from operand update to valid mul_p (1..15)
//
// Ports
//   clk              core clock
//   rst              asynchronous, active-high reset
//   exe              EXE handshake (muldiv_ctrl_if.slave)
//   mul_a, mul_b     registered 33-bit multiplier operands
//   mul_p            66-bit multiplier product
//   div_dividend     registered 33-bit dividend
//   div_divisor      registered 33-bit divisor
//   div_tvalid       dividend/divisor tvalid, high only in DIV_ISSUE
//   div_dout         divider output: quotient [71:40], remainder [31:0]
//   div_dout_tvalid  divider output valid
//------------------------------------------------------------------------------
module muldiv_ctrl #(
   parameter int unsigned MUL_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_ctrl_if.slave  exe,
   output logic [32:0]   mul_a,
   output logic [32:0]   mul_b,
   input  logic [65:0]   mul_p,
   output logic [32:0]   div_dividend,
   output logic [32:0]   div_divisor,
   output logic          div_tvalid,
   input  logic [79:0]   div_dout,
   input  logic          div_dout_tvalid
);

   localparam logic [3:0] LP_LAT = 4'(MUL_LAT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_WAIT,
      S_DIV_ISSUE,
      S_DIV_WAIT,
      S_DONE,
      S_DRAIN
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [32:0] r_mul_a;
   logic [32:0] r_mul_b;
   logic [32:0] r_div_dividend;
   logic [32:0] r_div_divisor;
   logic        r_div_tvalid;
   logic [31:0] r_res_hi;
   logic [31:0] r_res_lo;

   logic        w_req_ready;
   logic        w_accept;
   logic        w_unused;

   // Product guard bits and divider padding bytes carry no result information.
   assign w_unused = ^{mul_p[65:64], div_dout[79:72], div_dout[39:32]};

   function automatic logic [32:0] f_ext(input logic uns, input logic [31:0] v);
      return {(uns ? 1'b0 : v[31]), v};
   endfunction

   assign w_req_ready = (r_state == S_IDLE) & ~exe.flush;
   assign w_accept    = exe.req_valid & w_req_ready;

   assign exe.req_ready = w_req_ready;
   assign exe.busy      = (r_state != S_IDLE);
   assign exe.res_valid = (r_state == S_DONE);
   assign exe.res_hi    = r_res_hi;
   assign exe.res_lo    = r_res_lo;

   assign mul_a        = r_mul_a;
   assign mul_b        = r_mul_b;
   assign div_dividend = r_div_dividend;
   assign div_divisor  = r_div_divisor;
   assign div_tvalid   = r_div_tvalid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_mul_a        <= '0;
         r_mul_b        <= '0;
         r_div_dividend <= '0;
         r_div_divisor  <= '0;
         r_div_tvalid   <= 1'b0;
         r_res_hi       <= '0;
         r_res_lo       <= '0;
      end else begin
         // tvalid is only ever raised on the edge entering DIV_ISSUE, so it
         // is high for exactly that one state regardless of flush.
         r_div_tvalid <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt <= '0;
                  if (exe.req_div) begin
                     r_div_dividend <= f_ext(exe.req_unsigned, exe.req_src1);
                     r_div_divisor  <= f_ext(exe.req_unsigned, exe.req_src2);
                     r_div_tvalid   <= 1'b1;
                     r_state        <= S_DIV_ISSUE;
                  end else begin
                     r_mul_a <= f_ext(exe.req_unsigned, exe.req_src1);
                     r_mul_b <= f_ext(exe.req_unsigned, exe.req_src2);
                     r_state <= S_MUL_WAIT;
                  end
               end
            end

            S_MUL_WAIT: begin
               if (exe.flush) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == LP_LAT) begin
                  // Counter stops here rather than incrementing, so a 15-cycle
                  // latency never wraps the 4-bit count.
                  r_res_hi <= mul_p[63:32];
                  r_res_lo <= mul_p[31:0];
                  r_state  <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end

            S_DIV_ISSUE: begin
               // The divider has already taken the operands, so a flush here
               // must still wait for its output.
               r_state <= exe.flush ? S_DRAIN : S_DIV_WAIT;
            end

            S_DIV_WAIT: begin
               if (div_dout_tvalid) begin
                  if (exe.flush) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_res_lo <= div_dout[71:40];
                     r_res_hi <= div_dout[31:0];
                     r_state  <= S_DONE;
                  end
               end else if (exe.flush) begin
                  r_state <= S_DRAIN;
               end
            end

            S_DONE: begin
               if (exe.flush || exe.res_ack) begin
                  r_state <= S_IDLE;
               end
            end

            S_DRAIN: begin
               if (div_dout_tvalid) begin
                  r_state <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

   localparam int unsigned MUL_LAT   = 1;
   localparam int          DIV_DELAY = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   muldiv_ctrl_if u_if ();

   logic [32:0] mul_a, mul_b, div_dividend, div_divisor;
   logic [65:0] mul_p;
   logic        div_tvalid;
   logic [79:0] div_dout        = '0;
   logic        div_dout_tvalid = 1'b0;

   int n_checks = 0;
   int n_err    = 0;

   muldiv_ctrl #(.MUL_LAT(MUL_LAT)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .exe             (u_if),
      .mul_a           (mul_a),
      .mul_b           (mul_b),
      .mul_p           (mul_p),
      .div_dividend    (div_dividend),
      .div_divisor     (div_divisor),
      .div_tvalid      (div_tvalid),
      .div_dout        (div_dout),
      .div_dout_tvalid (div_dout_tvalid)
   );

   always #5 clk = ~clk;

   // ---------------- multiplier IP model: MUL_LAT-stage signed pipeline
   logic [65:0] mpipe [MUL_LAT];

   function automatic logic [65:0] mul66(input logic [32:0] a, input logic [32:0] b);
      logic signed [65:0] x, y;
      x = $signed(a);
      y = $signed(b);
      return x * y;
   endfunction

   initial for (int i = 0; i < MUL_LAT; i++) mpipe[i] = '0;

   always @(posedge clk) begin
      mpipe[0] <= mul66(mul_a, mul_b);
      for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_p = mpipe[MUL_LAT-1];

   // ---------------- divider IP model: answers DIV_DELAY cycles after tvalid
   function automatic logic [79:0] divcalc(input logic [32:0] dd, input logic [32:0] dv);
      longint a, b, q, r;
      a = longint'($signed(dd));
      b = longint'($signed(dv));
      if (b == 0) begin
         q = -1;
         r = a;
      end else begin
         q = a / b;
         r = a % b;
      end
      return {8'hA5, q[31:0], 8'h5A, r[31:0]};
   endfunction

   int dcnt = 0;
   always @(posedge clk) begin
      div_dout_tvalid <= 1'b0;
      if (div_tvalid) begin
         dcnt     <= DIV_DELAY;
         div_dout <= divcalc(div_dividend, div_divisor);
      end else if (dcnt > 0) begin
         dcnt <= dcnt - 1;
         if (dcnt == 1) div_dout_tvalid <= 1'b1;
      end
   end

   // ---------------- architectural reference: {HI, LO} from the ISA rules
   function automatic logic [63:0] ref_result(input logic dv, input logic uns,
                                              input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ua, ub, uq, ur;
      longint      sa, sb, sq, sr;
      if (!dv) begin
         if (uns) begin
            ua = {32'b0, a};
            ub = {32'b0, b};
            return ua * ub;
         end
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};   // divider's divide-by-zero output
      if (uns) begin
         ua = {32'b0, a};
         ub = {32'b0, b};
         uq = ua / ub;
         ur = ua % ub;
         return {ur[31:0], uq[31:0]};
      end
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      return {sr[31:0], sq[31:0]};
   endfunction

   // ---------------- helpers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic dv, input logic uns, input logic [31:0] a, input logic [31:0] b);
      int k = 0;
      while (!u_if.req_ready && k < 50) begin
         step();
         k++;
      end
      if (k == 50) check("ready_timeout", u_if.req_ready, 1'b1);
      u_if.req_div      = dv;
      u_if.req_unsigned = uns;
      u_if.req_src1     = a;
      u_if.req_src2     = b;
      u_if.req_valid    = 1'b1;
      step();
      u_if.req_valid    = 1'b0;
   endtask

   // Full op: issue, wait for result, check latency and data, hold, ack.
   task automatic run_op(input string tag, input logic dv, input logic uns,
                         input logic [31:0] a, input logic [31:0] b, input int hold);
      int          cyc = 0, dout_cyc = -1, tv_cnt = 0;
      logic [63:0] exp;
      exp = ref_result(dv, uns, a, b);
      issue(dv, uns, a, b);
      while (!u_if.res_valid && cyc < 100) begin
         if (div_tvalid) tv_cnt++;
         if (div_dout_tvalid) dout_cyc = cyc;
         step();
         cyc++;
      end
      check({tag, "_res_valid"}, u_if.res_valid, 1'b1);
      if (!dv) begin
         check({tag, "_mul_lat"}, cyc, MUL_LAT + 1);
      end else begin
         check({tag, "_tvalid_cycles"}, tv_cnt, 1);
         check({tag, "_div_lat"}, cyc, dout_cyc + 1);
      end
      check({tag, "_hi"}, u_if.res_hi, exp[63:32]);
      check({tag, "_lo"}, u_if.res_lo, exp[31:0]);
      for (int i = 0; i < hold; i++) begin
         step();
         check({tag, "_hold_rdy"}, u_if.req_ready, 1'b0);
         check({tag, "_hold_res"}, {u_if.res_valid, u_if.res_hi, u_if.res_lo}, {1'b1, exp});
      end
      u_if.res_ack = 1'b1;
      step();
      u_if.res_ack = 1'b0;
      check({tag, "_ack_rdy"}, u_if.req_ready, 1'b1);
      check({tag, "_ack_busy"}, u_if.busy, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] held;
      int          k;
      logic [31:0] ra, rb;
      logic        rdv, runs;

      u_if.req_valid    = 1'b0;
      u_if.req_div      = 1'b0;
      u_if.req_unsigned = 1'b0;
      u_if.req_src1     = '0;
      u_if.req_src2     = '0;
      u_if.flush        = 1'b0;
      u_if.res_ack      = 1'b0;

      // reset state
      #1;
      check("rst_ready", u_if.req_ready, 1'b1);
      check("rst_busy", u_if.busy, 1'b0);
      check("rst_res_valid", u_if.res_valid, 1'b0);
      check("rst_tvalid", div_tvalid, 1'b0);
      check("rst_res", {u_if.res_hi, u_if.res_lo}, 64'd0);
      step();
      step();
      rst = 1'b0;
      step();

      // signed / unsigned multiply
      run_op("mult", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 0);
      check("mult_mul_a", mul_a, 33'h1_FFFF_FFFF);
      run_op("multu", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2, 0);
      check("multu_mul_a", mul_a, 33'h0_FFFF_FFFF);
      check("multu_mul_b", mul_b, 33'h0_0000_0002);

      // signed divide 7 / -2
      run_op("div", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 0);
      check("div_dividend", div_dividend, 33'h0_0000_0007);
      check("div_divisor", div_divisor, 33'h1_FFFF_FFFE);

      // held result, then back-to-back MULT right after ack
      run_op("hold", 1'b0, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 5);
      run_op("b2b", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0001, 0);

      // divide boundaries
      run_op("div_ovf", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("div_zero", 1'b1, 1'b1, 32'hDEAD_BEEF, 32'd0, 0);
      run_op("divu", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);

      // flush 3 cycles into DIV_WAIT -> drain
      held = {u_if.res_hi, u_if.res_lo};
      issue(1'b1, 1'b0, 32'd100, 32'd7);
      step();            // DIV_WAIT
      step();
      step();
      step();
      u_if.flush = 1'b1;
      step();
      u_if.flush = 1'b0;
      k = 0;
      while (!div_dout_tvalid && k < 50) begin
         check("drain_rdy", u_if.req_ready, 1'b0);
         check("drain_res_valid", u_if.res_valid, 1'b0);
         step();
         k++;
      end
      check("drain_dout_seen", div_dout_tvalid, 1'b1);
      check("drain_rdy_at_dout", u_if.req_ready, 1'b0);
      step();
      check("drain_idle_busy", u_if.busy, 1'b0);
      check("drain_idle_rdy", u_if.req_ready, 1'b1);
      check("drain_res_kept", {u_if.res_hi, u_if.res_lo}, held);

      // flush in DIV_ISSUE -> drain
      issue(1'b1, 1'b1, 32'd50, 32'd3);
      u_if.flush = 1'b1;
      step();
      u_if.flush = 1'b0;
      check("issue_flush_tvalid", div_tvalid, 1'b0);
      check("issue_flush_busy", u_if.busy, 1'b1);
      k = 0;
      while (!div_dout_tvalid && k < 50) begin
         step();
         k++;
      end
      step();
      check("issue_flush_idle", u_if.busy, 1'b0);
      check("issue_flush_res", {u_if.res_hi, u_if.res_lo}, held);

      // flush coincident with divider output
      issue(1'b1, 1'b0, 32'hFFFF_FF00, 32'd5);
      k = 0;
      while (!div_dout_tvalid && k < 50) begin
         step();
         k++;
      end
      u_if.flush = 1'b1;
      step();
      u_if.flush = 1'b0;
      check("flush_dout_idle", u_if.busy, 1'b0);
      check("flush_dout_res", {u_if.res_hi, u_if.res_lo}, held);

      // flush in MUL_WAIT
      issue(1'b0, 1'b0, 32'd3, 32'd4);
      u_if.flush = 1'b1;
      step();
      u_if.flush = 1'b0;
      check("mul_flush_busy", u_if.busy, 1'b0);
      step();
      step();
      check("mul_flush_res_valid", u_if.res_valid, 1'b0);
      check("mul_flush_res", {u_if.res_hi, u_if.res_lo}, held);

      // flush in IDLE blocks acceptance
      u_if.flush     = 1'b1;
      u_if.req_valid = 1'b1;
      #1;
      check("idle_flush_rdy", u_if.req_ready, 1'b0);
      step();
      u_if.flush     = 1'b0;
      u_if.req_valid = 1'b0;
      check("idle_flush_busy", u_if.busy, 1'b0);

      // flush together with ack in DONE
      issue(1'b0, 1'b0, 32'd6, 32'd7);
      step();
      step();
      check("done_res_valid", u_if.res_valid, 1'b1);
      u_if.flush   = 1'b1;
      u_if.res_ack = 1'b1;
      step();
      u_if.flush   = 1'b0;
      u_if.res_ack = 1'b0;
      check("done_flush_busy", u_if.busy, 1'b0);
      check("done_flush_res", {u_if.res_hi, u_if.res_lo}, 64'd42);

      // randomized ops against the reference
      for (int n = 0; n < 40; n++) begin
         rdv  = 1'($urandom);
         runs = 1'($urandom);
         ra   = $urandom;
         rb   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if ($urandom_range(0, 3) == 0) ra = ra >> 24;
         if (rdv && rb == 32'd0) rb = 32'd1;
         run_op("rand", rdv, runs, ra, rb, $urandom_range(0, 3));
      end

      // asynchronous reset in the middle of MUL_WAIT
      run_op("pre_rst", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 0);
      issue(1'b0, 1'b0, 32'd9, 32'd9);
      check("mid_busy", u_if.busy, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", u_if.busy, 1'b0);
      check("arst_rdy", u_if.req_ready, 1'b1);
      check("arst_res", {u_if.res_hi, u_if.res_lo}, 64'd0);
      check("arst_mul_a", mul_a, 33'd0);
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check("post_rst_res_valid", u_if.res_valid, 1'b0);
         check("post_rst_busy", u_if.busy, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
